guess_round_ctrl: RTL and testbench



---
 rtl/guess_round_ctrl_pkg.sv | 23 ++
 rtl/guess_round_ctrl_if.sv | 32 +++
 rtl/guess_round_ctrl_tick_prescaler.sv | 34 +++
 rtl/guess_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_guess_round_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/guess_round_ctrl_pkg.sv
// Shared types for the guess round controller.
// Holds state_t, hint_t and the seconds-per-level constant.
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HINT_NONE = 2'b00,
    HINT_LOW  = 2'b01,
    HINT_HIGH = 2'b10,
    HINT_OK   = 2'b11
  } hint_t;

  localparam logic [6:0] SECS_PER_LEVEL = 7'd30;

endpackage

// File: rtl/guess_round_ctrl_if.sv
// Bundle between keypad/debounce logic and the round controller.
// master: drives start/difficulty/secret/guess/guess_valid,
// reads state/time_left/attempts/hint/win/lose. slave: the reverse.
interface guess_round_ctrl_if;

  logic       start;
  logic [1:0] difficulty;
  logic [6:0] secret;
  logic [6:0] guess;
  logic       guess_valid;
  logic [2:0] state;
  logic [6:0] time_left;
  logic [3:0] attempts;
  logic [1:0] hint;
  logic       win;
  logic       lose;

  modport master (
    output start, difficulty, secret,
    output guess, guess_valid,
    input  state, time_left, attempts,
    input  hint, win, lose
  );

  modport slave (
    input  start, difficulty, secret,
    input  guess, guess_valid,
    output state, time_left, attempts,
    output hint, win, lose
  );

endinterface

// File: rtl/guess_round_ctrl_tick_prescaler.sv
// Enable/clear counter producing one tick every TICK_DIV clocks.
// Ports: clk, rst (async high), en_i, clr_i, tick_o.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick_o  = en_i && !clr_i && at_last;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || !en_i || at_last) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer: load budget, grade guesses, count down, WIN/LOSE.
// Ports: clk, reset (async high), bus (guess_round_ctrl_if.slave).
// Option GUESS_PENALTY_EN: wrong guesses also cost PENALTY seconds.
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int MAX_GUESSES = 7,
  parameter int PENALTY     = 5
) (
  input logic                 clk,
  input logic                 reset,
  guess_round_ctrl_if.slave   bus
);

  localparam logic [3:0] MAXG = 4'(MAX_GUESSES);

  state_t     state_q, state_d;
  hint_t      hint_q, hint_d;
  logic [6:0] time_q, time_d;
  logic [3:0] att_q, att_d;
  logic [6:0] secret_q, secret_d;
  logic [6:0] guess_q, guess_d;
  logic [1:0] diff_q, diff_d;

  logic       run;
  logic       tick;
  logic       expire;
  logic [6:0] t_dec;
  logic [3:0] att_inc;

  assign run = (state_q == PLAY) ||
               (state_q == CHECK);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .rst    (reset),
    .en_i   (run),
    .clr_i  (state_q == LOAD),
    .tick_o (tick)
  );

  // time_left never sits at 0 in PLAY/CHECK, so no underflow.
  assign t_dec   = tick ? time_q - 7'd1 : time_q;
  assign expire  = tick && (time_q == 7'd1);
  assign att_inc = (att_q == 4'hF) ? att_q
                                   : att_q + 4'd1;

`ifdef GUESS_PENALTY_EN
  localparam logic [7:0] PEN = 8'(PENALTY);
  logic [7:0] pen_tot;
  logic       pen_zero;
  assign pen_tot  = PEN + {7'd0, tick};
  assign pen_zero = ({1'b0, time_q} <= pen_tot);
`endif

  always_comb begin
    state_d  = state_q;
    hint_d   = hint_q;
    time_d   = time_q;
    att_d    = att_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    diff_d   = diff_q;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (bus.start && bus.difficulty != 2'd0) begin
          state_d  = LOAD;
          secret_d = bus.secret;
          diff_d   = bus.difficulty;
        end
      end
      LOAD: begin
        time_d  = SECS_PER_LEVEL * {5'd0, diff_q};
        att_d   = 4'd0;
        hint_d  = HINT_NONE;
        state_d = PLAY;
      end
      PLAY: begin
        time_d = t_dec;
        if (bus.guess_valid) begin
          guess_d = bus.guess;
          state_d = CHECK;
        end
        if (expire) state_d = LOSE;
      end
      CHECK: begin
        att_d  = att_inc;
        time_d = t_dec;
        if (guess_q == secret_q) begin
          hint_d  = HINT_OK;
          state_d = WIN;
        end else begin
          hint_d = (guess_q < secret_q) ? HINT_LOW
                                        : HINT_HIGH;
          state_d = PLAY;
          if (att_inc == MAXG) state_d = LOSE;
          if (expire)          state_d = LOSE;
`ifdef GUESS_PENALTY_EN
          if (pen_zero) begin
            time_d  = 7'd0;
            state_d = LOSE;
          end else begin
            time_d = 7'({1'b0, time_q} - pen_tot);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hint_q   <= HINT_NONE;
      time_q   <= 7'd0;
      att_q    <= 4'd0;
      secret_q <= 7'd0;
      guess_q  <= 7'd0;
      diff_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      hint_q   <= hint_d;
      time_q   <= time_d;
      att_q    <= att_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      diff_q   <= diff_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.time_left = time_q;
  assign bus.attempts  = att_q;
  assign bus.hint      = hint_q;
  assign bus.win       = (state_q == WIN);
  assign bus.lose      = (state_q == LOSE);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl (TICK_DIV=4, MAX_GUESSES=3).
// Expected values are hand-computed per step.
module tb_guess_round_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  guess_round_ctrl_if bus ();

  guess_round_ctrl #(
    .TICK_DIV    (4),
    .MAX_GUESSES (3),
    .PENALTY     (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_round(
    input logic [1:0] d,
    input logic [6:0] s
  );
    bus.difficulty = d;
    bus.secret     = s;
    bus.start      = 1'b1;
    step(1);
    bus.start      = 1'b0;
  endtask

  task automatic do_guess(input logic [6:0] g);
    bus.guess       = g;
    bus.guess_valid = 1'b1;
    step(1);
    bus.guess_valid = 1'b0;
    step(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.start       = 1'b0;
    bus.difficulty  = 2'd0;
    bus.secret      = 7'd0;
    bus.guess       = 7'd0;
    bus.guess_valid = 1'b0;
    step(2);
    chk("rst_state", bus.state, 0);
    chk("rst_time", bus.time_left, 0);
    chk("rst_att", bus.attempts, 0);
    chk("rst_hint", bus.hint, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_lose", bus.lose, 0);
    reset = 1'b0;
    step(1);

    // round 1: diff 2, secret 42
    start_round(2'd2, 7'd42);
    chk("load_state", bus.state, 1);
    step(1);
    chk("play_state", bus.state, 2);
    chk("play_time60", bus.time_left, 60);
    step(8);
    chk("time58", bus.time_left, 58);

    do_guess(7'd10);
    chk("g10_hint", bus.hint, 1);
    chk("g10_att", bus.attempts, 1);
    chk("g10_state", bus.state, 2);
    do_guess(7'd80);
    chk("g80_hint", bus.hint, 2);
    chk("g80_att", bus.attempts, 2);
    chk("g80_time", bus.time_left, 57);
    do_guess(7'd42);
    chk("g42_hint", bus.hint, 3);
    chk("g42_att", bus.attempts, 3);
    chk("win_flag", bus.win, 1);
    chk("win_state", bus.state, 4);
    chk("win_time", bus.time_left, 57);
    step(20);
    chk("win_hold_time", bus.time_left, 57);
    chk("win_hold_state", bus.state, 4);
    chk("win_hold_hint", bus.hint, 3);

    // round 2: diff 1, let it expire
    start_round(2'd1, 7'd9);
    chk("r2_load", bus.state, 1);
    step(1);
    chk("r2_time30", bus.time_left, 30);
    step(119);
    chk("r2_t1", bus.time_left, 1);
    chk("r2_play", bus.state, 2);
    step(1);
    chk("exp_state", bus.state, 5);
    chk("exp_lose", bus.lose, 1);
    chk("exp_time", bus.time_left, 0);
    start_round(2'd0, 7'd9);
    chk("diff0_ign", bus.state, 5);
    start_round(2'd3, 7'd9);
    chk("r3_load", bus.state, 1);
    step(1);
    chk("r3_time90", bus.time_left, 90);
    step(132);
    chk("r3_time57", bus.time_left, 57);

    // async reset mid-PLAY
    reset = 1'b1;
    #1;
    chk("mrst_state", bus.state, 0);
    chk("mrst_time", bus.time_left, 0);
    chk("mrst_att", bus.attempts, 0);
    chk("mrst_hint", bus.hint, 0);
    step(1);
    reset = 1'b0;
    step(1);

    // round 4: three wrong guesses
    start_round(2'd3, 7'd100);
    step(1);
    chk("r4_time90", bus.time_left, 90);
    do_guess(7'd5);
    chk("r4_g1_hint", bus.hint, 1);
    do_guess(7'd20);
    chk("r4_g2_att", bus.attempts, 2);
    chk("r4_g2_time", bus.time_left, 89);
    do_guess(7'd120);
    chk("max_lose", bus.lose, 1);
    chk("max_state", bus.state, 5);
    chk("max_att", bus.attempts, 3);
    chk("max_hint", bus.hint, 2);
    chk("max_time", bus.time_left, 89);
    do_guess(7'd100);
    chk("lose_gv_att", bus.attempts, 3);
    chk("lose_gv_st", bus.state, 5);

    // round 5: wrong guess at time_left 4
    start_round(2'd1, 7'd50);
    step(1);
    step(104);
    chk("r5_time4", bus.time_left, 4);
    do_guess(7'd10);
    chk("r5_hint", bus.hint, 1);
    chk("r5_att", bus.attempts, 1);
`ifdef GUESS_PENALTY_EN
    chk("pen_time", bus.time_left, 0);
    chk("pen_lose", bus.lose, 1);
    chk("pen_state", bus.state, 5);
`else
    chk("nopen_time", bus.time_left, 4);
    chk("nopen_lose", bus.lose, 0);
    chk("nopen_state", bus.state, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
